// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: steps the coordinate LFSRs, rejects off-grid
// candidates and confirms free cells with the snake-body occupancy store.
module food_spawn_ctrl #(
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int COORD_W   = 10,
  parameter int MAX_TRIES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_req,
  input  logic [COORD_W-1:0] lfsr_x,
  input  logic [COORD_W-1:0] lfsr_y,
  output logic               lfsr_step,
  output logic               occ_valid,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_ack,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               spawn_done,
  output logic               spawn_fail,
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STEP   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_QUERY  = 2'd3;

  // One extra bit so a grid dimension of exactly 2**COORD_W still compares correctly.
  localparam logic [COORD_W:0] GRID_W_C    = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0] GRID_H_C    = (COORD_W+1)'(GRID_H);
  localparam logic [7:0]       MAX_TRIES_C = 8'(MAX_TRIES);

  logic [1:0]         state;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic [7:0]         tries;
  logic [7:0]         tries_inc;
  logic               in_range;

  assign tries_inc = tries + 8'd1;
  assign in_range  = ({1'b0, lfsr_x} < GRID_W_C) && ({1'b0, lfsr_y} < GRID_H_C);

  // Handshake strobes decode straight from the state register.
  assign lfsr_step = (state == S_STEP);
  assign occ_valid = (state == S_QUERY);
  assign busy      = (state != S_IDLE);
  assign occ_x     = cand_x;
  assign occ_y     = cand_y;

  // NOTE: every register here is a plain flop with a synchronous reset, and all
  // sequential updates use <= so each branch sees pre-edge values consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cand_x     <= '0;
      cand_y     <= '0;
      tries      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
    end else begin
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
      case (state)
        S_IDLE: begin
          if (spawn_req) begin
            food_valid <= 1'b0;
            tries      <= '0;
            state      <= S_STEP;
          end
        end
        S_STEP: begin
          state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          cand_x <= lfsr_x;
          cand_y <= lfsr_y;
          tries  <= tries_inc;
          if (in_range) begin
            state <= S_QUERY;
          end else if (tries_inc < MAX_TRIES_C) begin
            state <= S_STEP;
          end else begin
            spawn_fail <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_QUERY: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              food_x     <= cand_x;
              food_y     <= cand_y;
              food_valid <= 1'b1;
              spawn_done <= 1'b1;
              state      <= S_IDLE;
            end else if (tries < MAX_TRIES_C) begin
              state <= S_STEP;
            end else begin
              spawn_fail <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Self-checking bench for food_spawn_ctrl: bench-side LFSR and occupancy
// responders plus a candidate-by-candidate reference model of each request.
module tb_food_spawn_ctrl;

  localparam int GW = 64;
  localparam int GH = 48;
  localparam int CW = 10;
  localparam int MT = 4;
  localparam int CYCLE_BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          spawn_req;
  logic [CW-1:0] lfsr_x;
  logic [CW-1:0] lfsr_y;
  logic          lfsr_step;
  logic          occ_valid;
  logic [CW-1:0] occ_x;
  logic [CW-1:0] occ_y;
  logic          occ_ack;
  logic          occ_hit;
  logic [CW-1:0] food_x;
  logic [CW-1:0] food_y;
  logic          food_valid;
  logic          spawn_done;
  logic          spawn_fail;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  food_spawn_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .MAX_TRIES(MT)
  ) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req),
    .lfsr_x(lfsr_x), .lfsr_y(lfsr_y), .lfsr_step(lfsr_step),
    .occ_valid(occ_valid), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .spawn_done(spawn_done), .spawn_fail(spawn_fail), .busy(busy)
  );

  // Stimulus plan and bench state shared with the responders.
  logic [CW-1:0] plan_x[$];
  logic [CW-1:0] plan_y[$];
  logic [CW-1:0] lfsr_qx[$];
  logic [CW-1:0] lfsr_qy[$];
  logic [CW-1:0] log_x[$];
  logic [CW-1:0] log_y[$];
  bit            occ_map [GW][GH];
  int            ack_delay = 0;
  bit            force_ack = 1'b0;
  int            wait_cnt  = 0;
  logic [CW-1:0] m_fx = '0;
  logic [CW-1:0] m_fy = '0;
  logic          m_fv = 1'b0;

  function automatic bit hit_at(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (int'(x) < GW && int'(y) < GH) return occ_map[x[5:0]][y[5:0]];
    return 1'b0;
  endfunction

  // LFSR block model: presents the next planned value after each step.
  always @(negedge clk) begin
    if (lfsr_step === 1'b1) begin
      if (lfsr_qx.size() > 0) begin
        lfsr_x = lfsr_qx.pop_front();
        lfsr_y = lfsr_qy.pop_front();
      end else begin
        lfsr_x = CW'($urandom_range(200, 1023));
        lfsr_y = CW'($urandom_range(0, 1023));
      end
    end
  end

  // Occupancy responder: acks after ack_delay waiting cycles, logs each answered query.
  always @(negedge clk) begin
    if (force_ack) begin
      occ_ack = 1'b1;
      occ_hit = 1'b0;
    end else if (occ_valid === 1'b1 && rst !== 1'b1) begin
      if (wait_cnt >= ack_delay) begin
        occ_ack = 1'b1;
        occ_hit = hit_at(occ_x, occ_y);
        log_x.push_back(occ_x);
        log_y.push_back(occ_y);
      end else begin
        occ_ack = 1'b0;
        occ_hit = 1'($urandom);
        wait_cnt++;
      end
    end else begin
      occ_ack  = 1'b0;
      occ_hit  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic clear_map();
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++)
        occ_map[x][y] = 1'b0;
  endtask

  task automatic set_plan2(input int x0, input int y0, input int x1, input int y1);
    plan_x.delete(); plan_y.delete();
    plan_x.push_back(CW'(x0)); plan_y.push_back(CW'(y0));
    plan_x.push_back(CW'(x1)); plan_y.push_back(CW'(y1));
  endtask

  task automatic idle_check(input string name, input int n);
    bit bad = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (lfsr_step !== 1'b0 || busy !== 1'b0 || occ_valid !== 1'b0 ||
          spawn_done !== 1'b0 || spawn_fail !== 1'b0 ||
          food_valid !== m_fv || food_x !== m_fx || food_y !== m_fy) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL %s: activity while idle, food=(%0d,%0d,v%0b) want (%0d,%0d,v%0b)",
               name, food_x, food_y, food_valid, m_fx, m_fy, m_fv);
    end
  endtask

  // One request: model the expected outcome, run it, compare everything observable.
  task automatic run_spawn(input string name, input bit poke_req);
    bit            exp_ok = 1'b0;
    logic [CW-1:0] exp_fx = m_fx;
    logic [CW-1:0] exp_fy = m_fy;
    int            exp_steps = 0;
    int            exp_lat = 0;
    logic [CW-1:0] eq_x[$];
    logic [CW-1:0] eq_y[$];
    int            steps = 0;
    int            vcyc = 0;
    int            cyc = 0;
    bit            inv_bad = 1'b0;
    bit            prev_step = 1'b0;
    bit            prev_valid = 1'b0;
    bit            poked = 1'b0;
    bit            first_in;
    logic [CW-1:0] hold_x = '0;
    logic [CW-1:0] hold_y = '0;

    for (int i = 0; i < MT && i < plan_x.size(); i++) begin
      exp_steps++;
      if (int'(plan_x[i]) < GW && int'(plan_y[i]) < GH) begin
        exp_lat += 3 + ack_delay;
        eq_x.push_back(plan_x[i]);
        eq_y.push_back(plan_y[i]);
        if (!occ_map[plan_x[i][5:0]][plan_y[i][5:0]]) begin
          exp_ok = 1'b1;
          exp_fx = plan_x[i];
          exp_fy = plan_y[i];
          break;
        end
      end else begin
        exp_lat += 2;
      end
    end
    first_in = (int'(plan_x[0]) < GW && int'(plan_y[0]) < GH);

    lfsr_qx = plan_x;
    lfsr_qy = plan_y;
    log_x.delete(); log_y.delete();

    spawn_req = 1'b1;
    @(posedge clk); #1;
    spawn_req = 1'b0;

    n_checks++;
    if (lfsr_step !== 1'b1 || busy !== 1'b1 || food_valid !== 1'b0 ||
        spawn_done !== 1'b0 || spawn_fail !== 1'b0) begin
      n_errors++;
      $display("FAIL %s accept: step=%b busy=%b fv=%b done=%b fail=%b want 1 1 0 0 0",
               name, lfsr_step, busy, food_valid, spawn_done, spawn_fail);
    end

    while (cyc < CYCLE_BUDGET) begin
      if (spawn_done === 1'b1 || spawn_fail === 1'b1) break;
      if (lfsr_step === 1'b1) begin
        steps++;
        if (prev_step) inv_bad = 1'b1;
      end
      if (lfsr_step === 1'b1 && occ_valid === 1'b1) inv_bad = 1'b1;
      if (occ_valid === 1'b1) begin
        vcyc++;
        if (prev_valid && (occ_x !== hold_x || occ_y !== hold_y)) inv_bad = 1'b1;
        hold_x = occ_x;
        hold_y = occ_y;
      end
      if (busy !== 1'b1 || food_valid !== 1'b0 || food_x !== m_fx || food_y !== m_fy)
        inv_bad = 1'b1;
      if (cyc == 2) begin
        n_checks++;
        if (occ_valid !== first_in || (first_in && (occ_x !== plan_x[0] || occ_y !== plan_y[0]))) begin
          n_errors++;
          $display("FAIL %s first_query: valid=%b (%0d,%0d) want valid=%b (%0d,%0d)",
                   name, occ_valid, occ_x, occ_y, first_in, plan_x[0], plan_y[0]);
        end
      end
      if (poke_req && occ_valid === 1'b1 && !poked) begin
        spawn_req = 1'b1;
        poked = 1'b1;
      end else begin
        spawn_req = 1'b0;
      end
      prev_step  = (lfsr_step === 1'b1);
      prev_valid = (occ_valid === 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    spawn_req = 1'b0;

    n_checks++;
    if (cyc >= CYCLE_BUDGET) begin
      n_errors++;
      $display("FAIL %s timeout: no done/fail within %0d cycles", name, CYCLE_BUDGET);
    end
    n_checks++;
    if (spawn_done !== exp_ok || spawn_fail !== !exp_ok) begin
      n_errors++;
      $display("FAIL %s outcome: done=%b fail=%b want done=%b", name, spawn_done, spawn_fail, exp_ok);
    end
    n_checks++;
    if (cyc != exp_lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, exp_lat);
    end
    n_checks++;
    if (steps != exp_steps) begin
      n_errors++;
      $display("FAIL %s steps: got %0d want %0d", name, steps, exp_steps);
    end
    n_checks++;
    if (vcyc != eq_x.size() * (ack_delay + 1)) begin
      n_errors++;
      $display("FAIL %s occ_valid_cycles: got %0d want %0d", name, vcyc, eq_x.size() * (ack_delay + 1));
    end
    n_checks++;
    if (log_x.size() != eq_x.size()) begin
      n_errors++;
      $display("FAIL %s query_count: got %0d want %0d", name, log_x.size(), eq_x.size());
    end else begin
      for (int i = 0; i < eq_x.size(); i++) begin
        n_checks++;
        if (log_x[i] !== eq_x[i] || log_y[i] !== eq_y[i]) begin
          n_errors++;
          $display("FAIL %s query[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   name, i, log_x[i], log_y[i], eq_x[i], eq_y[i]);
        end
      end
    end
    n_checks++;
    if (food_valid !== exp_ok || food_x !== exp_fx || food_y !== exp_fy || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s food: got (%0d,%0d,v%b) busy=%b want (%0d,%0d,v%b) busy=0",
               name, food_x, food_y, food_valid, busy, exp_fx, exp_fy, exp_ok);
    end
    n_checks++;
    if (inv_bad) begin
      n_errors++;
      $display("FAIL %s invariants: got a step/query/hold violation want none", name);
    end
    m_fx = exp_fx;
    m_fy = exp_fy;
    m_fv = exp_ok;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if ({lfsr_step, occ_valid, occ_x, occ_y, food_x, food_y, food_valid,
         spawn_done, spawn_fail, busy} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: step=%b qv=%b q=(%0d,%0d) food=(%0d,%0d,v%b) done=%b fail=%b busy=%b want all 0",
               lfsr_step, occ_valid, occ_x, occ_y, food_x, food_y, food_valid, spawn_done, spawn_fail, busy);
    end
    rst = 1'b0;
    m_fx = '0; m_fy = '0; m_fv = 1'b0;
    idle_check("idle_after_reset", 20);
  endtask

  task automatic test_direct();
    clear_map();
    ack_delay = 0;
    set_plan2(5, 7, 200, 0);
    run_spawn("direct", 1'b0);
  endtask

  task automatic test_range();
    ack_delay = 0;
    set_plan2(70, 7, 12, 47);
    run_spawn("range_x", 1'b0);
    set_plan2(12, 48, 0, 0);
    run_spawn("range_y", 1'b0);
    set_plan2(64, 0, 63, 47);
    run_spawn("range_edge", 1'b0);
  endtask

  task automatic test_occupied();
    clear_map();
    occ_map[3][3] = 1'b1;
    ack_delay = 4;
    set_plan2(3, 3, 4, 3);
    run_spawn("occupied", 1'b0);
    idle_check("occupied_one_done", 3);
    clear_map();
  endtask

  task automatic test_exhaustion();
    ack_delay = 0;
    set_plan2(100, 0, 0, 48);
    plan_x.push_back(CW'(1023)); plan_y.push_back(CW'(1023));
    plan_x.push_back(CW'(64));   plan_y.push_back(CW'(47));
    run_spawn("exhaust_range", 1'b0);
    idle_check("exhaust_range_idle", 3);
    clear_map();
    set_plan2(1, 1, 2, 2);
    plan_x.push_back(CW'(3)); plan_y.push_back(CW'(3));
    plan_x.push_back(CW'(4)); plan_y.push_back(CW'(4));
    for (int i = 1; i <= 4; i++) occ_map[i][i] = 1'b1;
    ack_delay = 1;
    run_spawn("exhaust_hits", 1'b0);
    clear_map();
  endtask

  task automatic test_ignored_req();
    ack_delay = 3;
    set_plan2(20, 30, 200, 0);
    run_spawn("ignored_req", 1'b1);
    idle_check("ignored_req_idle", 6);
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    set_plan2(8, 9, 200, 0);
    run_spawn("b2b_first", 1'b0);
    set_plan2(99, 0, 10, 11);
    run_spawn("b2b_second", 1'b0);
  endtask

  task automatic test_reset_mid_query();
    int waited = 0;
    ack_delay = 1000;
    set_plan2(10, 10, 200, 0);
    lfsr_qx = plan_x;
    lfsr_qy = plan_y;
    spawn_req = 1'b1;
    @(posedge clk); #1;
    spawn_req = 1'b0;
    while (occ_valid !== 1'b1 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (occ_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_reach_query: occ_valid=%b want 1 within 10 cycles", occ_valid);
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (occ_valid !== 1'b0 || busy !== 1'b0 || lfsr_step !== 1'b0 ||
        food_valid !== 1'b0 || food_x !== '0 || food_y !== '0 || occ_x !== '0 || occ_y !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_values: qv=%b busy=%b step=%b food=(%0d,%0d,v%b) q=(%0d,%0d) want all 0",
               occ_valid, busy, lfsr_step, food_x, food_y, food_valid, occ_x, occ_y);
    end
    rst = 1'b0;
    m_fx = '0; m_fy = '0; m_fv = 1'b0;
    lfsr_qx.delete(); lfsr_qy.delete();
    force_ack = 1'b1;
    idle_check("rst_mid_stale_ack", 3);
    force_ack = 1'b0;
    ack_delay = 0;
    idle_check("rst_mid_settle", 2);
    set_plan2(33, 44, 200, 0);
    run_spawn("rst_mid_recover", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      for (int x = 0; x < GW; x++)
        for (int y = 0; y < GH; y++)
          occ_map[x][y] = ($urandom_range(0, 9) < 3);
      plan_x.delete(); plan_y.delete();
      for (int i = 0; i < MT + 2; i++) begin
        plan_x.push_back(CW'($urandom_range(0, 90)));
        plan_y.push_back(CW'($urandom_range(0, 70)));
      end
      ack_delay = int'($urandom_range(0, 3));
      run_spawn($sformatf("random%0d", it), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("random%0d_idle", it), 2);
    end
    clear_map();
  endtask

  initial begin
    rst       = 1'b1;
    spawn_req = 1'b0;
    lfsr_x    = '0;
    lfsr_y    = '0;
    occ_ack   = 1'b0;
    occ_hit   = 1'b0;
    clear_map();
    test_reset();
    test_direct();
    test_range();
    test_occupied();
    test_exhaustion();
    test_ignored_req();
    test_back_to_back();
    test_reset_mid_query();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
